// File: rtl/vpu_sram_arbiter_if.sv
// rtl/vpu_sram_arbiter_if.sv - requester and SRAM bus bundle for vpu_sram_arbiter
interface vpu_sram_arbiter_if #(
    parameter int DATA_W = 1024,
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_we;
    logic              p0_re;
    logic              p0_ready;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_err;

    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_we;
    logic              p1_re;
    logic              p1_ready;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_err;

    logic              err_clr;

    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_we;
    logic              sram_re;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_ready;

    logic              busy;

    modport slave (
        input  p0_addr, p0_wdata, p0_we, p0_re,
        input  p1_addr, p1_wdata, p1_we, p1_re,
        input  err_clr, sram_rdata, sram_ready,
        output p0_ready, p0_rdata, p0_err,
        output p1_ready, p1_rdata, p1_err,
        output sram_addr, sram_wdata, sram_we, sram_re, busy
    );

    modport master (
        output p0_addr, p0_wdata, p0_we, p0_re,
        output p1_addr, p1_wdata, p1_we, p1_re,
        output err_clr, sram_rdata, sram_ready,
        input  p0_ready, p0_rdata, p0_err,
        input  p1_ready, p1_rdata, p1_err,
        input  sram_addr, sram_wdata, sram_we, sram_re, busy
    );
endinterface

// File: rtl/vpu_sram_arbiter.sv
// rtl/vpu_sram_arbiter.sv - round-robin arbiter sharing one SRAM port between two requesters
module vpu_sram_arbiter #(
    parameter int DATA_W  = 1024,
    parameter int ADDR_W  = 20,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst_n,
    vpu_sram_arbiter_if.slave bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state, state_next;

    logic [ADDR_W-1:0] req_addr  [2];
    logic [DATA_W-1:0] req_wdata [2];
    logic [1:0]        req_we, req_re;

    logic [ADDR_W-1:0] buf_addr  [2];
    logic [DATA_W-1:0] buf_wdata [2];
    logic [1:0]        buf_we;
    logic [DATA_W-1:0] rdata_q   [2];

    logic [1:0] pending, pending_next, capture, err_set, err_q, ready_q, clr_mask;
    logic       rr_ptr, gnt, gnt_we, gnt_sel, grant, done, abort;
    logic [CNT_W-1:0]  wd_cnt;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] sram_wdata_q;
    logic              sram_we_q, sram_re_q;

    assign req_addr[0]  = bus.p0_addr;
    assign req_addr[1]  = bus.p1_addr;
    assign req_wdata[0] = bus.p0_wdata;
    assign req_wdata[1] = bus.p1_wdata;
    assign req_we       = {bus.p1_we, bus.p0_we};
    assign req_re       = {bus.p1_re, bus.p0_re};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        gnt_sel    = pending[rr_ptr] ? rr_ptr : ~rr_ptr;
        case (state)
            S_IDLE: begin
                if (|pending) begin
                    grant      = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.sram_ready) begin
                    done       = 1'b1;
                    state_next = S_IDLE;
                end else if (TIMEOUT != 0 && wd_cnt == CNT_LAST) begin
                    abort      = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Completion frees the buffer before this cycle's strobe is judged, so a
    // requester may re-issue on the same edge its previous access retires.
    always_comb begin
        clr_mask = '0;
        if (done || abort) clr_mask[gnt] = 1'b1;
        pending_next = pending & ~clr_mask;
        capture      = '0;
        err_set      = '0;
        for (int n = 0; n < 2; n++) begin
            if (req_we[n] && req_re[n]) begin
                err_set[n] = 1'b1;
            end else if (req_we[n] || req_re[n]) begin
                if (pending_next[n]) begin
                    err_set[n] = 1'b1;
                end else begin
                    capture[n]      = 1'b1;
                    pending_next[n] = 1'b1;
                end
            end
        end
        if (abort) err_set[gnt] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            err_q        <= '0;
            ready_q      <= '0;
            rr_ptr       <= 1'b0;
            gnt          <= 1'b0;
            gnt_we       <= 1'b0;
            wd_cnt       <= '0;
            buf_we       <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_we_q    <= 1'b0;
            sram_re_q    <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                buf_addr[n]  <= '0;
                buf_wdata[n] <= '0;
                rdata_q[n]   <= '0;
            end
        end else begin
            pending   <= pending_next;
            err_q     <= (err_q & ~{2{bus.err_clr}}) | err_set;
            ready_q   <= clr_mask;
            sram_we_q <= 1'b0;
            sram_re_q <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                if (capture[n]) begin
                    buf_addr[n]  <= req_addr[n];
                    buf_wdata[n] <= req_wdata[n];
                    buf_we[n]    <= req_we[n];
                end
            end
            if (grant) begin
                sram_addr_q  <= buf_addr[gnt_sel];
                sram_wdata_q <= buf_wdata[gnt_sel];
                sram_we_q    <= buf_we[gnt_sel];
                sram_re_q    <= ~buf_we[gnt_sel];
                gnt          <= gnt_sel;
                gnt_we       <= buf_we[gnt_sel];
                wd_cnt       <= '0;
            end else if (state == S_WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (done || abort) rr_ptr <= ~gnt;
            if (done && !gnt_we) rdata_q[gnt] <= bus.sram_rdata;
        end
    end

    assign bus.p0_ready   = ready_q[0];
    assign bus.p1_ready   = ready_q[1];
    assign bus.p0_rdata   = rdata_q[0];
    assign bus.p1_rdata   = rdata_q[1];
    assign bus.p0_err     = err_q[0];
    assign bus.p1_err     = err_q[1];
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_wdata = sram_wdata_q;
    assign bus.sram_we    = sram_we_q;
    assign bus.sram_re    = sram_re_q;
    assign bus.busy       = (state != S_IDLE) || (|pending);
endmodule
